// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;

  // Key code width for a rows x cols matrix; never narrower than one bit.
  function automatic int calc_cw(input int rows, input int cols);
    int n;
    n = rows * cols;
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE,
    PRESSED
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } cls_e;

endpackage

// File: rtl/keypad_scan_if.sv
// Pin-side and event-side signals of the keypad scanner.
// master: the scanner itself; slave: board pins / game controller side.
interface keypad_scan_if
  import keypad_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int CW   = calc_cw(ROWS, COLS)
);
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic            key_valid;
  logic [CW-1:0]   key_code;
  logic            key_down;
  logic            key_release;

  modport master (
    output row_n, key_valid, key_code, key_down, key_release,
    input  col_n
  );

  modport slave (
    input  row_n, key_valid, key_code, key_down, key_release,
    output col_n
  );
endinterface

// File: rtl/keypad_scan_col_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Resets to all ones, i.e. "no key pulling the line low".
module keypad_col_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  // Metastability chain: two back-to-back flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/keypad_scan.sv
// Row-scanning keypad matrix reader with whole-frame debounce.
// Drives one row low per SCAN_DIV clocks, builds a snapshot of the matrix,
// classifies each completed frame and reports debounced press/release events.
//
// state   | meaning
// IDLE    | no key accepted as held
// PRESSED | key_code accepted and still considered held
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS            = ROWS_DEF,
  parameter int COLS            = COLS_DEF,
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kp
);
  localparam int CW = calc_cw(ROWS, COLS);
  localparam int N  = ROWS * COLS;
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [SW-1:0] DF_MAX   = SW'(DEBOUNCE_FRAMES);
  localparam logic [SW-1:0] DF_PRE   = SW'(DEBOUNCE_FRAMES - 1);

  logic [COLS-1:0] col_s;

  logic [DW-1:0]   div_q;
  logic [RW-1:0]   row_q;
  logic [ROWS-1:0] row_n_q;
  logic [N-1:0]    snap_q;
  logic            frame_end_q;
  logic            tick;

  cls_e            cls;
  logic [CW-1:0]   code;
  cls_e            prev_cls_q;
  logic [CW-1:0]   prev_code_q;
  logic [SW-1:0]   stable_cnt_q;
  logic            same;
  logic            stable_evt;

  state_e          state_q, state_d;
  logic            key_valid_q, key_valid_d;
  logic            key_release_q, key_release_d;
  logic            key_down_q, key_down_d;
  logic [CW-1:0]   key_code_q, key_code_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   pend_code_q, pend_code_d;

  keypad_col_sync #(.W(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d_i (kp.col_n),
    .q_o (col_s)
  );

  assign tick = (div_q == DIV_LAST);

  // Row timer: sample the driven row at the end of its period, then step to the next row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      row_q       <= '0;
      row_n_q     <= ~ROWS'(1);
      snap_q      <= '0;
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= tick && (row_q == ROW_LAST);
      if (tick) begin
        div_q                          <= '0;
        snap_q[int'(row_q)*COLS +: COLS] <= ~col_s;
        row_q                          <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        row_n_q                        <= {row_n_q[ROWS-2:0], row_n_q[ROWS-1]};
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Frame classifier: none / exactly one key (with its code) / several keys.
  always_comb begin
    cls  = CLS_NONE;
    code = '0;
    for (int i = 0; i < N; i++) begin
      if (snap_q[i]) begin
        if (cls == CLS_NONE) begin
          cls  = CLS_SINGLE;
          code = CW'(i);
        end else begin
          cls = CLS_MULTI;
        end
      end
    end
  end

  assign same = (cls == prev_cls_q) && ((cls != CLS_SINGLE) || (code == prev_code_q));

  // Fires only on the frame where the run of identical frames first hits the threshold.
  assign stable_evt = frame_end_q &&
                      (same ? (stable_cnt_q == DF_PRE) : (DEBOUNCE_FRAMES == 1));

  // Debounce counter: length of the current run of identical frame classifications.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cls_q   <= CLS_NONE;
      prev_code_q  <= '0;
      stable_cnt_q <= '0;
    end else if (frame_end_q) begin
      if (same) begin
        if (stable_cnt_q != DF_MAX) stable_cnt_q <= stable_cnt_q + 1'b1;
      end else begin
        stable_cnt_q <= SW'(1);
        prev_cls_q   <= cls;
        prev_code_q  <= code;
      end
    end
  end

  // Event FSM next state; a roll-over releases first and replays the new key from IDLE.
  always_comb begin
    state_d       = state_q;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_down_d    = key_down_q;
    key_code_d    = key_code_q;
    pend_d        = 1'b0;
    pend_code_d   = pend_code_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          key_valid_d = 1'b1;
          key_code_d  = pend_code_q;
          key_down_d  = 1'b1;
          state_d     = PRESSED;
        end else if (stable_evt && (cls == CLS_SINGLE)) begin
          key_valid_d = 1'b1;
          key_code_d  = code;
          key_down_d  = 1'b1;
          state_d     = PRESSED;
        end
      end
      PRESSED: begin
        if (stable_evt && (cls == CLS_NONE)) begin
          key_release_d = 1'b1;
          key_down_d    = 1'b0;
          state_d       = IDLE;
        end else if (stable_evt && (cls == CLS_SINGLE) && (code != key_code_q)) begin
          key_release_d = 1'b1;
          key_down_d    = 1'b0;
          pend_d        = 1'b1;
          pend_code_d   = code;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Event FSM registers; outputs are registered so pulses are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      key_valid_q   <= 1'b0;
      key_release_q <= 1'b0;
      key_down_q    <= 1'b0;
      key_code_q    <= '0;
      pend_q        <= 1'b0;
      pend_code_q   <= '0;
    end else begin
      state_q       <= state_d;
      key_valid_q   <= key_valid_d;
      key_release_q <= key_release_d;
      key_down_q    <= key_down_d;
      key_code_q    <= key_code_d;
      pend_q        <= pend_d;
      pend_code_q   <= pend_code_d;
    end
  end

  assign kp.row_n       = row_n_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_release = key_release_q;
  assign kp.key_down    = key_down_q;
  assign kp.key_code    = key_code_q;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: 4x4 matrix, 4 clocks per row, 3-frame debounce.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int SCAN_DIV = 4;
  localparam int DF = 3;
  localparam int FR = ROWS * SCAN_DIV;

  logic clk = 1'b0;
  logic rst;
  logic [ROWS*COLS-1:0] keys;
  logic [COLS-1:0] col_drv;

  int checks = 0;
  int errors = 0;
  int pcnt = 0;
  int n_valid = 0, n_rel = 0, n_down = 0, n_overlap = 0;
  int valid_cyc = 0, rel_cyc = 0, last_code = 0;
  int p0, v0, r0, d0;
  bit ok;

  always #5 clk = ~clk;

  keypad_scan_if #(.ROWS(ROWS), .COLS(COLS)) u_if ();

  keypad_scan #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (u_if.master)
  );

  // Matrix model: a held key pulls its column low only while its row is driven.
  always_comb begin
    col_drv = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (keys[r*COLS+c] && !u_if.row_n[r]) col_drv[c] = 1'b0;
  end
  assign u_if.col_n = col_drv;

  // Posedges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) pcnt <= 0;
    else     pcnt <= pcnt + 1;
  end

  // Event monitor.
  always @(negedge clk) begin
    if (u_if.key_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= pcnt;
      last_code <= int'(u_if.key_code);
    end
    if (u_if.key_release) begin
      n_rel   <= n_rel + 1;
      rel_cyc <= pcnt;
    end
    if (u_if.key_down) n_down <= n_down + 1;
    if (u_if.key_valid && u_if.key_release) n_overlap <= n_overlap + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic to_boundary();
    int g;
    g = 0;
    do begin
      step(1);
      g++;
    end while ((pcnt % FR != 0) && g < 2*FR);
  endtask

  task automatic wait_valid(input int base, input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      if (n_valid > base) begin
        seen = 1;
        break;
      end
      step(1);
    end
  endtask

  task automatic wait_rel(input int base, input int limit, output bit seen);
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      if (n_rel > base) begin
        seen = 1;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    rst  = 1'b1;
    keys = '0;
    step(3);
    chk("rst_row_n", int'(u_if.row_n), 4'b1110);
    chk("rst_valid", int'(u_if.key_valid), 0);
    chk("rst_code", int'(u_if.key_code), 0);
    chk("rst_down", int'(u_if.key_down), 0);
    chk("rst_release", int'(u_if.key_release), 0);

    // Row sequence after release: each row held for SCAN_DIV clocks.
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4*FR; i++) begin
      logic [3:0] e;
      e = ~(4'd1 << ((i / SCAN_DIV) % ROWS));
      chk("row_seq", int'(u_if.row_n), int'(e));
      step(1);
    end
    v0 = n_valid; r0 = n_rel; d0 = n_down;
    step(6*FR);
    chk("idle_valid", n_valid - v0, 0);
    chk("idle_release", n_rel - r0, 0);
    chk("idle_down", n_down - d0, 0);
    chk("idle_code", int'(u_if.key_code), 0);

    // Clean press of key 9 (row 2, col 1), then release.
    to_boundary();
    p0 = pcnt; v0 = n_valid;
    keys[9] = 1'b1;
    wait_valid(v0, 6*FR, ok);
    chk("press9_seen", int'(ok), 1);
    chk_rng("press9_lat", valid_cyc - p0, 3*FR + 1, 3*FR + 2);
    chk("press9_code", last_code, 9);
    step(40);
    chk("press9_once", n_valid - v0, 1);
    chk("press9_down", int'(u_if.key_down), 1);
    chk("press9_out_code", int'(u_if.key_code), 9);
    to_boundary();
    p0 = pcnt; r0 = n_rel;
    keys = '0;
    wait_rel(r0, 6*FR, ok);
    chk("rel9_seen", int'(ok), 1);
    chk_rng("rel9_lat", rel_cyc - p0, 3*FR + 1, 3*FR + 2);
    step(8);
    chk("rel9_down", int'(u_if.key_down), 0);
    chk("rel9_code_held", int'(u_if.key_code), 9);
    chk("rel9_once", n_rel - r0, 1);

    // Bounce on key 5: toggles every 7 clocks, frames go S5, NONE, S5, S5, S5.
    to_boundary();
    p0 = pcnt; v0 = n_valid;
    keys[5] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step(7);
      keys[5] = ~keys[5];
    end
    step(42);
    chk("bounce_quiet", n_valid - v0, 0);
    wait_valid(v0, 4*FR, ok);
    chk("bounce_seen", int'(ok), 1);
    chk_rng("bounce_lat", valid_cyc - p0, 5*FR + 1, 5*FR + 2);
    chk("bounce_code", last_code, 5);
    r0 = n_rel;
    keys = '0;
    wait_rel(r0, 6*FR, ok);
    chk("bounce_rel_seen", int'(ok), 1);

    // Keys 0 and 15 together: ignored; dropping 15 leaves a clean press of 0.
    to_boundary();
    v0 = n_valid; d0 = n_down;
    keys[0]  = 1'b1;
    keys[15] = 1'b1;
    step(6*FR);
    chk("multi_no_valid", n_valid - v0, 0);
    chk("multi_no_down", n_down - d0, 0);
    chk("multi_down_lvl", int'(u_if.key_down), 0);
    p0 = pcnt;
    keys[15] = 1'b0;
    wait_valid(v0, 6*FR, ok);
    chk("multi_then0_seen", int'(ok), 1);
    chk_rng("multi_then0_lat", valid_cyc - p0, 3*FR + 1, 3*FR + 2);
    chk("multi_then0_code", last_code, 0);
    r0 = n_rel;
    keys = '0;
    wait_rel(r0, 6*FR, ok);
    chk("multi_rel_seen", int'(ok), 1);

    // Roll-over from key 3 to key 12 with no clean release.
    to_boundary();
    v0 = n_valid;
    keys[3] = 1'b1;
    wait_valid(v0, 6*FR, ok);
    chk("roll3_seen", int'(ok), 1);
    chk("roll3_code", last_code, 3);
    to_boundary();
    p0 = pcnt; r0 = n_rel; v0 = n_valid;
    keys = '0;
    keys[12] = 1'b1;
    wait_rel(r0, 6*FR, ok);
    chk("roll_rel_seen", int'(ok), 1);
    chk_rng("roll_rel_lat", rel_cyc - p0, 3*FR + 1, 3*FR + 2);
    wait_valid(v0, 10, ok);
    chk("roll12_seen", int'(ok), 1);
    chk("roll12_next_cycle", valid_cyc - rel_cyc, 1);
    chk("roll12_code", last_code, 12);
    step(2);
    chk("roll12_down", int'(u_if.key_down), 1);
    chk("roll_rel_once", n_rel - r0, 1);
    r0 = n_rel;
    keys = '0;
    wait_rel(r0, 6*FR, ok);
    chk("roll12_rel_seen", int'(ok), 1);

    // Reset while key 7 is held.
    to_boundary();
    v0 = n_valid;
    keys[7] = 1'b1;
    wait_valid(v0, 6*FR, ok);
    chk("rst7_seen", int'(ok), 1);
    chk("rst7_code", last_code, 7);
    step(5);
    chk("rst7_down_before", int'(u_if.key_down), 1);
    r0 = n_rel;
    rst = 1'b1;
    #1;
    chk("rst_async_down", int'(u_if.key_down), 0);
    chk("rst_async_code", int'(u_if.key_code), 0);
    chk("rst_async_valid", int'(u_if.key_valid), 0);
    chk("rst_async_release", int'(u_if.key_release), 0);
    chk("rst_async_row_n", int'(u_if.row_n), 4'b1110);
    step(2);
    rst = 1'b0;
    v0 = n_valid;
    wait_valid(v0, 6*FR, ok);
    chk("rst7_again_seen", int'(ok), 1);
    chk_rng("rst7_again_lat", valid_cyc, 3*FR + 1, 3*FR + 2);
    chk("rst7_again_code", last_code, 7);
    chk("rst7_no_release", n_rel - r0, 0);
    keys = '0;
    step(2);

    chk("no_overlap", n_overlap, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
